// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: serially sums weighted active inputs, fires on threshold.
// Latency: trig edge 0 -> spike high in cycle INPUTS+2; trig while busy is dropped.
module lif_neuron #(
    parameter int INPUTS      = 25,
    parameter int WEIGHT_BITS = 2,
    parameter int ACC_BITS    = 8,
    parameter int VT          = 59,
    parameter int LEAK        = 0,
    parameter int REFRAC      = 0
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic [INPUTS*WEIGHT_BITS-1:0]   weights,
    input  logic [INPUTS-1:0]               signals,
    input  logic                            trig,
    input  logic                            latinhib_bus,
    output logic                            spike,
    output logic                            busy,
    output logic [ACC_BITS-1:0]             membrane
);

    localparam int IW      = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int RW      = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;
    localparam int ACC_MAX = (1 << ACC_BITS) - 1;

    localparam logic [ACC_BITS-1:0] VT_V   = ACC_BITS'(VT);
    localparam logic [ACC_BITS-1:0] LEAK_V = ACC_BITS'((LEAK > ACC_MAX) ? ACC_MAX : LEAK);
    localparam logic [IW-1:0]       LAST   = IW'(INPUTS - 1);
    localparam logic [RW-1:0]       REF_LD = RW'((REFRAC > 0) ? REFRAC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_EVAL,
        S_REFRAC
    } state_t;

    state_t                         state, state_n;
    logic [IW-1:0]                  idx, idx_n;
    logic [RW-1:0]                  rcnt, rcnt_n;
    logic [ACC_BITS-1:0]            mem_n;
    logic                           spike_n;
    logic                           capture;
    logic [INPUTS-1:0]              sig_q;
    logic [INPUTS*WEIGHT_BITS-1:0]  w_q;

    logic [WEIGHT_BITS-1:0]         cur_w;
    logic [ACC_BITS:0]              sum_ext;
    logic [ACC_BITS-1:0]            add_val;
    logic [ACC_BITS-1:0]            leaked;

    // Carry out of the widened sum means the accumulator would wrap: clamp instead.
    assign cur_w   = w_q[idx*WEIGHT_BITS +: WEIGHT_BITS];
    assign sum_ext = {1'b0, membrane} + (ACC_BITS+1)'(cur_w);
    assign add_val = !sig_q[idx]      ? membrane :
                     sum_ext[ACC_BITS] ? {ACC_BITS{1'b1}} : sum_ext[ACC_BITS-1:0];
    assign leaked  = (membrane > LEAK_V) ? (membrane - LEAK_V) : '0;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        rcnt_n  = rcnt;
        mem_n   = membrane;
        spike_n = 1'b0;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig) begin
                    state_n = S_SCAN;
                    idx_n   = '0;
                    capture = 1'b1;
                end
            end
            S_SCAN: begin
                if (latinhib_bus) begin
                    mem_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    mem_n = add_val;
                    idx_n = idx + 1'b1;
                    if (idx == LAST) begin
                        state_n = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                // Inhibition wins over a pending fire.
                if (latinhib_bus) begin
                    mem_n   = '0;
                    state_n = S_IDLE;
                end else if (membrane >= VT_V) begin
                    mem_n   = '0;
                    spike_n = 1'b1;
                    if (REFRAC > 0) begin
                        state_n = S_REFRAC;
                        rcnt_n  = REF_LD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    mem_n   = leaked;
                    state_n = S_IDLE;
                end
            end
            S_REFRAC: begin
                mem_n = '0;
                if (rcnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    rcnt_n = rcnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            idx      <= '0;
            rcnt     <= '0;
            membrane <= '0;
            spike    <= 1'b0;
            sig_q    <= '0;
            w_q      <= '0;
        end else begin
            idx      <= idx_n;
            rcnt     <= rcnt_n;
            membrane <= mem_n;
            spike    <= spike_n;
            if (capture) begin
                sig_q <= signals;
                w_q   <= weights;
            end
        end
    end

endmodule
